// File: rtl/seg7_pkg.sv
// Shared glyph codes and selector encodings for the 4-digit status display.
// All segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_U     = 7'h41;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_R     = 7'h2F;
  localparam logic [6:0] GLYPH_P     = 7'h0C;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    KIND_NUM   = 3'd0,
    KIND_U     = 3'd1,
    KIND_D     = 3'd2,
    KIND_R     = 3'd3,
    KIND_P     = 3'd4,
    KIND_BLANK = 3'd5
  } glyph_kind_t;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph lookup: a numeric digit or one of the status letters.
// Digit codes above 9 have no glyph and render blank.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] kind,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (kind)
      KIND_NUM: begin
        case (digit)
          4'd0:    glyph = GLYPH_0;
          4'd1:    glyph = GLYPH_1;
          4'd2:    glyph = GLYPH_2;
          4'd3:    glyph = GLYPH_3;
          4'd4:    glyph = GLYPH_4;
          4'd5:    glyph = GLYPH_5;
          4'd6:    glyph = GLYPH_6;
          4'd7:    glyph = GLYPH_7;
          4'd8:    glyph = GLYPH_8;
          4'd9:    glyph = GLYPH_9;
          default: glyph = GLYPH_BLANK;
        endcase
      end
      KIND_U:  glyph = GLYPH_U;
      KIND_D:  glyph = GLYPH_D;
      KIND_R:  glyph = GLYPH_R;
      KIND_P:  glyph = GLYPH_P;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_status_display.sv
// Multiplexed 4-digit status display for the up/down counter: value, direction
// and run/stop, snapshotted once per frame, numeric digits blinking while stopped.
module seg7_status_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       dir_up,
  input  logic       running,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_TICKS - 1);

  logic [PW-1:0]    p;
  logic [IDX_W-1:0] idx;
  logic [3:0]       snap_value;
  logic             snap_dir_up;
  logic             snap_running;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;
  logic             tick;
  logic             frame_wrap;

  assign tick       = (p == P_LAST);
  assign frame_wrap = tick && (idx == IDX_W'(3));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p            <= '0;
      idx          <= '0;
      snap_value   <= '0;
      snap_dir_up  <= 1'b0;
      snap_running <= 1'b0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else begin
      p <= tick ? '0 : p + PW'(1);
      if (tick)
        idx <= idx + IDX_W'(1);
      if (frame_wrap) begin
        snap_value   <= value;
        snap_dir_up  <= dir_up;
        snap_running <= running;
      end
      // A restart captured at the frame wrap clears the phase in the same
      // cycle so the digits are solid from the very next frame.
      if ((frame_wrap && running) || snap_running) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == B_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Stage p0: glyph selection for the current slot
  logic [3:0] units_p0;
  logic [3:0] digit_p0;
  logic [2:0] kind_p0;
  logic [6:0] glyph_p0;

  assign units_p0 = (snap_value >= 4'd10) ? snap_value - 4'd10 : snap_value;

  always_comb begin
    digit_p0 = 4'd0;
    kind_p0  = KIND_BLANK;
    case (idx)
      2'd0: begin
        digit_p0 = units_p0;
        kind_p0  = blink_phase ? KIND_BLANK : KIND_NUM;
      end
      2'd1: begin
        digit_p0 = 4'd1;
        kind_p0  = (blink_phase || snap_value < 4'd10) ? KIND_BLANK : KIND_NUM;
      end
      2'd2:    kind_p0 = snap_dir_up ? KIND_U : KIND_D;
      default: kind_p0 = snap_running ? KIND_R : KIND_P;
    endcase
  end

  seg7_glyph_rom u_rom (
    .digit (digit_p0),
    .kind  (kind_p0),
    .glyph (glyph_p0)
  );

  // Stage p1: registered pin drivers
  logic [3:0] an_p1;
  logic [6:0] seg_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_p1  <= 4'hF;
      seg_p1 <= GLYPH_BLANK;
    end else if (p < P_BLANK || glyph_p0 == GLYPH_BLANK) begin
      an_p1  <= 4'hF;
      seg_p1 <= GLYPH_BLANK;
    end else begin
      an_p1  <= ~(4'b0001 << idx);
      seg_p1 <= glyph_p0;
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;

endmodule

// File: tb/tb_seg7_status_display.sv
// Directed bench for seg7_status_display with a small refresh divider; expected
// {an,seg} per cycle is queued ahead of time and popped as the DUT advances.
module tb_seg7_status_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLANK_CYC   = 1;
  localparam int BLINK_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] value = 4'd0;
  logic       dir_up = 1'b0;
  logic       running = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  logic [10:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_status_display #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .BLINK_TICKS (BLINK_TICKS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .dir_up  (dir_up),
    .running (running),
    .an      (an),
    .seg     (seg)
  );

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: an=%h seg=%h, expected an=%h seg=%h",
             tag, obs[10:7], obs[6:0], exp_v[10:7], exp_v[6:0]);
    end
  endtask

  task automatic check_phase(input string tag, input logic exp_v);
    n_tests++;
    assert (dut.blink_phase === exp_v) else begin
      n_fail++;
      $error("FAIL %s: blink_phase=%b, expected %b", tag, dut.blink_phase, exp_v);
    end
  endtask

  // One slot: a blanking cycle, then three cycles of the digit (or blank).
  task automatic push_slot(input logic [3:0] an_e, input logic [6:0] seg_e);
    exp_q.push_back({4'hF, 7'h7F});
    for (int i = 0; i < 3; i++)
      exp_q.push_back((seg_e == 7'h7F) ? {4'hF, 7'h7F} : {an_e, seg_e});
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    push_slot(4'hE, s0);
    push_slot(4'hD, s1);
    push_slot(4'hB, s2);
    push_slot(4'h7, s3);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: scoreboard empty at cycle %0d", tag, i);
      end else begin
        check(tag, {an, seg}, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    // Reset held: pins dark regardless of inputs
    value   = 4'd9;
    running = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {an, seg}, {4'hF, 7'h7F});
    end

    rst     = 1'b1;
    value   = 4'd7;
    dir_up  = 1'b1;
    running = 1'b1;
    // Frame 0 shows the reset snapshot: 0, 'd', 'P'
    push_frame(7'h40, 7'h7F, 7'h21, 7'h0C);
    run("frame0_reset_snap", 16);

    // Frame 1: value 7 running up; a change during idx=1 must not tear
    push_frame(7'h78, 7'h7F, 7'h41, 7'h2F);
    run("frame1_a", 6);
    value = 4'd3;
    run("frame1_no_tear", 10);
    check_phase("phase_running", 1'b0);

    // Frame 2: the 3 appears only after the wrap
    value = 4'd12;
    push_frame(7'h30, 7'h7F, 7'h41, 7'h2F);
    run("frame2_value3", 16);

    // Frame 3: two-digit value 12; stop the counter for the next frame
    running = 1'b0;
    value   = 4'd5;
    dir_up  = 1'b0;
    push_frame(7'h24, 7'h79, 7'h41, 7'h2F);
    run("frame3_value12", 16);

    // Frames 4-5: stopped, blink period equals one frame so digit0 lands in phase 0
    push_frame(7'h12, 7'h7F, 7'h21, 7'h0C);
    run("frame4_stop_a", 8);
    check_phase("phase_after_2_ticks", 1'b1);
    run("frame4_stop_b", 8);
    check_phase("phase_after_4_ticks", 1'b0);
    push_frame(7'h12, 7'h7F, 7'h21, 7'h0C);
    run("frame5_stop_a", 8);
    check_phase("phase_frame5_mid", 1'b1);
    running = 1'b1;
    run("frame5_stop_b", 8);
    check_phase("phase_restart", 1'b0);

    // Frame 6: restarted, digits steady
    push_frame(7'h12, 7'h7F, 7'h21, 7'h2F);
    run("frame6_restart", 16);
    check_phase("phase_restart_hold", 1'b0);

    // Asynchronous reset while digit0 is lit
    exp_q.push_back({4'hF, 7'h7F});
    exp_q.push_back({4'hE, 7'h12});
    run("frame7_before_reset", 2);
    #3 rst = 1'b0;
    #1 check("async_reset_midslot", {an, seg}, {4'hF, 7'h7F});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("async_reset_hold", {an, seg}, {4'hF, 7'h7F});
    end
    rst = 1'b1;
    // First lit segment BLANK_CYC+1 cycles after release, from the reset snapshot
    exp_q.push_back({4'hF, 7'h7F});
    exp_q.push_back({4'hE, 7'h40});
    run("post_reset_first", 2);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
